float_to_fixed_conv: RTL and testbench
======================================

Name: float_to_fixed_conv

Overview:
- Iterative, handshaked converter from IEEE-754 single-precision to 32-bit two's-complement fixed point, with a run-time fractional-bit count.
- Inverse of the datapath's fix-to-float conversion path; both share the same `fixpointpos` convention.
- Sits between the float producer and fixed-point consumers.
- The shifter moves a bounded number of bits per cycle to keep the critical path short.

Parameters:
- SHIFT_STEP, 4, maximum bit positions shifted per SHIFT cycle (legal values 1..8).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  float_in/fixpointpos are valid
- in_ready  output  1  block can accept an input
- float_in  input  32  IEEE-754 single {sign, exp[7:0], frac[22:0]}
- fixpointpos  input  5  number of fractional bits in the result (0..31)
- out_valid  output  1  fixed_out and flags are valid
- out_ready  input  1  consumer accepts the result
- fixed_out  output  32  two's-complement fixed result
- overflow  output  1  result was saturated
- invalid  output  1  input was NaN

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE, in_ready = 1, out_valid = 0, fixed_out = 0, overflow = 0, invalid = 0.
  - Any in-flight conversion is discarded.
- Input accept:
  - Accept occurs on a rising edge where in_valid && in_ready.
  - float_in and fixpointpos are captured on that edge.
  - in_ready is 1 only in IDLE and drops on the accept edge.
- States:
  - IDLE: wait for accept, then go to SETUP.
  - SETUP: one cycle. Decode and classify the input. Load mag = {1, frac} (24 bits, zero-extended to 32). Compute sh = exp - 150 + fixpointpos (signed). Compute N = ceil(|sh| / SHIFT_STEP). Go to SHIFT if N > 0, otherwise go to FINISH.
  - SHIFT: shift mag by min(SHIFT_STEP, remaining) per cycle. Shift left if sh > 0, right if sh < 0. Right shifts discard bits (truncation toward zero). Go to FINISH when remaining = 0.
  - FINISH: one cycle. Drive fixed_out = sign ? -mag : mag, set flags, set out_valid = 1, go to HOLD.
  - HOLD: hold out_valid, fixed_out and the flags stable while out_ready = 0. On the edge where out_valid && out_ready: out_valid = 0, in_ready = 1, go to IDLE.
- Latency: out_valid rises N + 2 rising edges after the accept edge.
- Throughput: one conversion in flight. There is no accept during HOLD, even if out_ready is high.
- SETUP classification, in priority order (N = 0 for every case that resolves here):
  - exp = 255, frac ≠ 0 (NaN): result 0, invalid = 1, overflow = 0.
  - exp = 255, frac = 0 (±inf): saturate, overflow = 1.
  - exp = 0 (zero or denormal): result 0, both flags 0. Denormals flush to zero.
  - sh < -23: result 0, flags 0 (truncates to zero).
  - sh ≥ 8:
    - If sign = 1, sh = 8 and frac = 0: exact -2^31, result 0x80000000, overflow = 0.
    - Otherwise: saturate, overflow = 1.
  - -23 ≤ sh ≤ 7: normal shift path. The magnitude fits in 31 bits, so no overflow.
- Saturation values: positive 0x7FFFFFFF, negative 0x80000000.
- Negative zero (0x80000000 input) produces fixed_out = 0.
- Flags are valid only while out_valid = 1. They are cleared when the next conversion is accepted.
- Width rules:
  - sh is computed in at least 10-bit signed arithmetic.
  - mag is 32 bits.
  - Negation is a 32-bit two's complement.

Test Plan:
- Exact conversion and latency: 0x3FC00000 (1.5), fixpointpos = 8, SHIFT_STEP = 4, out_ready = 1 -> fixed_out = 0x00000180, flags 0. sh = -15 gives N = 4, so out_valid rises exactly 6 edges after accept.
- Negative input: 0xC0300000 (-2.75), fixpointpos = 4 -> fixed_out = 0xFFFFFFD4 (-44).
- Saturation and the exact minimum, fixpointpos = 0:
  - 0x4F000000 (2^31) -> 0x7FFFFFFF, overflow = 1.
  - 0xCF000000 (-2^31) -> 0x80000000, overflow = 0.
  - 0xFF800000 (-inf) -> 0x80000000, overflow = 1.
- Special and small values:
  - 0x7FC00000 (NaN) -> 0, invalid = 1.
  - 0x00000001 (denormal) -> 0.
  - 0x3F7FFFFF, fixpointpos = 0 -> 0 (truncation).
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid rises -> fixed_out and flags are stable, in_ready = 0, and an in_valid pulse is ignored. Raising out_ready returns the block to IDLE with in_ready = 1 on the next edge.
- Reset mid-operation: assert rst during SHIFT -> out_valid = 0, in_ready = 1 and fixed_out = 0 immediately (asynchronous). After release, a new input converts correctly.

Source files
------------

// File: rtl/float_to_fixed_conv.sv
// IEEE-754 single to 32-bit two's-complement fixed point converter with a run-time
// fractional-bit count; the magnitude is shifted at most SHIFT_STEP bits per cycle.
module float_to_fixed_conv #(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] float_in,
  input  logic [4:0]  fixpointpos,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] fixed_out,
  output logic        overflow,
  output logic        invalid
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] SHIFT  = 3'd2;
  localparam logic [2:0] FINISH = 3'd3;
  localparam logic [2:0] HOLD   = 3'd4;

  localparam logic [7:0]  STEP    = 8'(SHIFT_STEP);
  localparam logic [31:0] POS_SAT = 32'h7FFF_FFFF;
  localparam logic [31:0] NEG_SAT = 32'h8000_0000;

  logic [2:0]  state;
  logic        sign_q;
  logic [7:0]  exp_q;
  logic [22:0] frac_q;
  logic [4:0]  fpp_q;
  logic [31:0] mag_q;
  logic [7:0]  rem_q;
  logic        left_q;
  logic        sat_q;
  logic        zero_q;
  logic        ovf_q;
  logic        inv_q;

  logic signed [9:0] sh;
  logic [7:0]  sh_abs;
  logic        cls_nan;
  logic        cls_sat;
  logic        cls_zero;
  logic        cls_exact_min;
  logic        cls_normal;
  logic [7:0]  step_amt;
  logic [31:0] mag_shifted;
  logic [31:0] result;

  assign in_ready = (state == IDLE);

  // Classify the captured operand; priority order matters because exp = 255 also
  // produces a large shift distance and must never reach the range checks.
  always_comb begin
    sh = $signed({2'b00, exp_q}) - 10'sd150 + $signed({5'b00000, fpp_q});
    sh_abs = sh[9] ? 8'(-sh) : 8'(sh);
    cls_nan = 1'b0;
    cls_sat = 1'b0;
    cls_zero = 1'b0;
    cls_exact_min = 1'b0;
    cls_normal = 1'b0;
    if (exp_q == 8'hFF) begin
      if (frac_q != 23'd0) begin
        cls_nan = 1'b1;
        cls_zero = 1'b1;
      end else begin
        cls_sat = 1'b1;
      end
    end else if (exp_q == 8'h00) begin
      cls_zero = 1'b1;
    end else if (sh < -10'sd23) begin
      cls_zero = 1'b1;
    end else if (sh >= 10'sd8) begin
      if (sign_q && (sh == 10'sd8) && (frac_q == 23'd0)) begin
        cls_exact_min = 1'b1;
      end else begin
        cls_sat = 1'b1;
      end
    end else begin
      cls_normal = 1'b1;
    end
  end

  always_comb begin
    step_amt = (rem_q < STEP) ? rem_q : STEP;
    mag_shifted = left_q ? (mag_q << step_amt) : (mag_q >> step_amt);
  end

  always_comb begin
    if (zero_q) begin
      result = 32'd0;
    end else if (sat_q) begin
      result = sign_q ? NEG_SAT : POS_SAT;
    end else begin
      result = sign_q ? (~mag_q + 32'd1) : mag_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sign_q    <= 1'b0;
      exp_q     <= 8'd0;
      frac_q    <= 23'd0;
      fpp_q     <= 5'd0;
      mag_q     <= 32'd0;
      rem_q     <= 8'd0;
      left_q    <= 1'b0;
      sat_q     <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      inv_q     <= 1'b0;
      out_valid <= 1'b0;
      fixed_out <= 32'd0;
      overflow  <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q   <= float_in[31];
            exp_q    <= float_in[30:23];
            frac_q   <= float_in[22:0];
            fpp_q    <= fixpointpos;
            overflow <= 1'b0;
            invalid  <= 1'b0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          sat_q  <= cls_sat;
          zero_q <= cls_zero;
          ovf_q  <= cls_sat;
          inv_q  <= cls_nan;
          mag_q  <= cls_exact_min ? NEG_SAT : {8'h00, 1'b1, frac_q};
          rem_q  <= cls_normal ? sh_abs : 8'd0;
          left_q <= ~sh[9];
          state  <= (cls_normal && (sh_abs != 8'd0)) ? SHIFT : FINISH;
        end
        SHIFT: begin
          mag_q <= mag_shifted;
          rem_q <= rem_q - step_amt;
          if (rem_q == step_amt) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          fixed_out <= result;
          overflow  <= ovf_q;
          invalid   <= inv_q;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_fixed_conv.sv
// Randomized self-checking bench for float_to_fixed_conv against a plain-arithmetic
// reference model of the float-to-fixed rules.
module tb_float_to_fixed_conv;

  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] float_in = 32'd0;
  logic [4:0]  fixpointpos = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] fixed_out;
  logic        overflow;
  logic        invalid;

  int total = 0;
  int bad = 0;

  logic [31:0] exp_fixed;
  logic        exp_ovf;
  logic        exp_inv;
  int          exp_lat;
  logic        chk_en = 1'b0;

  float_to_fixed_conv #(.SHIFT_STEP(STEP)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .float_in(float_in),
    .fixpointpos(fixpointpos),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .fixed_out(fixed_out),
    .overflow(overflow),
    .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
    end
  endtask

  // Value = {1,frac} * 2^(exp-150+fpp), truncated toward zero, then range-checked.
  function automatic void model(input logic [31:0] f, input logic [4:0] p,
                                output logic [31:0] r, output logic ov,
                                output logic inv, output int lat);
    int e;
    int sh;
    int ash;
    longint m;
    longint mag;
    bit s;
    e = int'(f[30:23]);
    s = f[31];
    sh = e - 150 + int'(p);
    r = 32'd0;
    ov = 1'b0;
    inv = 1'b0;
    lat = 2;
    if (e == 255) begin
      if (f[22:0] != 23'd0) inv = 1'b1;
      else begin
        ov = 1'b1;
        r = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
      return;
    end
    if (e == 0) return;
    m = longint'({1'b1, f[22:0]});
    if (sh >= 40) mag = 64'h1_0000_0000;
    else if (sh >= 0) mag = m << sh;
    else if (sh <= -40) mag = 0;
    else mag = m >> (-sh);
    if ((!s && mag > 64'd2147483647) || (s && mag > 64'd2147483648)) begin
      ov = 1'b1;
      r = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      r = s ? 32'(-mag) : 32'(mag);
    end
    if (sh >= -23 && sh <= 7) begin
      ash = (sh < 0) ? -sh : sh;
      lat = 2 + (ash + STEP - 1) / STEP;
    end
  endfunction

  // Output compare on every cycle the result is presented, including held cycles.
  always @(negedge clk) begin
    if (!rst && chk_en && out_valid) begin
      checkOutput("fixed_out", fixed_out, exp_fixed);
      checkOutput("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
      checkOutput("invalid", {31'd0, invalid}, {31'd0, exp_inv});
    end
  end

  task automatic applyStimulus(input logic [31:0] f, input logic [4:0] p, input int stall);
    int lat;
    int guard;
    model(f, p, exp_fixed, exp_ovf, exp_inv, exp_lat);
    chk_en = 1'b1;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) checkOutput("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    float_in = f;
    fixpointpos = p;
    out_ready = (stall == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("flags_clear", {30'd0, overflow, invalid}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(exp_lat));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      in_valid = (i == 0);
      float_in = $urandom;
      fixpointpos = 5'($urandom_range(0, 31));
      @(posedge clk);
      #1;
      checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("done_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("done_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic pinModel(input logic [31:0] f, input logic [4:0] p, input logic [31:0] r_want,
                          input logic ov_want, input logic inv_want);
    logic [31:0] r;
    logic ov;
    logic inv;
    int lat;
    model(f, p, r, ov, inv, lat);
    checkOutput("model_value", r, r_want);
    checkOutput("model_flags", {30'd0, ov, inv}, {30'd0, ov_want, inv_want});
  endtask

  initial begin
    logic [31:0] f;
    logic [7:0] e;
    logic [31:0] r;
    logic ov;
    logic inv;
    int lat;

    pinModel(32'h3FC0_0000, 5'd8, 32'h0000_0180, 1'b0, 1'b0);
    pinModel(32'hC030_0000, 5'd4, 32'hFFFF_FFD4, 1'b0, 1'b0);
    pinModel(32'h4F00_0000, 5'd0, 32'h7FFF_FFFF, 1'b1, 1'b0);
    pinModel(32'hCF00_0000, 5'd0, 32'h8000_0000, 1'b0, 1'b0);
    pinModel(32'hFF80_0000, 5'd0, 32'h8000_0000, 1'b1, 1'b0);
    pinModel(32'h7FC0_0000, 5'd0, 32'h0000_0000, 1'b0, 1'b1);
    model(32'h3FC0_0000, 5'd8, r, ov, inv, lat);
    checkOutput("model_latency", 32'(lat), 32'd6);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_fixed_out", fixed_out, 32'd0);
    checkOutput("rst_flags", {30'd0, overflow, invalid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(32'h3FC0_0000, 5'd8, 0);
    applyStimulus(32'hC030_0000, 5'd4, 0);
    applyStimulus(32'h4F00_0000, 5'd0, 1);
    applyStimulus(32'hCF00_0000, 5'd0, 0);
    applyStimulus(32'hFF80_0000, 5'd0, 0);
    applyStimulus(32'h7F80_0000, 5'd31, 0);
    applyStimulus(32'h7FC0_0000, 5'd0, 0);
    applyStimulus(32'h0000_0001, 5'd31, 0);
    applyStimulus(32'h8000_0000, 5'd12, 0);
    applyStimulus(32'h3F7F_FFFF, 5'd0, 0);
    applyStimulus(32'h3FC0_0000, 5'd8, 5);

    // Leave a nonzero result behind, then reset while the next one is shifting.
    applyStimulus(32'hC030_0000, 5'd4, 0);
    @(negedge clk);
    in_valid = 1'b1;
    float_in = 32'h3FC0_0000;
    fixpointpos = 5'd8;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("midrst_fixed_out", fixed_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(32'h4049_0FDB, 5'd16, 0);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0: e = 8'hFF;
        1: e = 8'h00;
        default: e = 8'($urandom_range(100, 175));
      endcase
      f = {1'($urandom_range(0, 1)), e, 23'($urandom)};
      if ($urandom_range(0, 7) == 0) f[22:0] = 23'd0;
      applyStimulus(f, 5'($urandom_range(0, 31)), $urandom_range(0, 3));
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
